fetch_queue: RTL and testbench

Dual-issue instruction queue between the fetch stage and the `decode_issue` pipeline register. Fetch writes up to two instructions per cycle, each with its PC and branch-predict bit. The queue presents the two oldest entries, in program order, to `decode_issue`, and the issue logic pops 0, 1 or 2 of them per cycle. This decouples fetch bandwidth from issue pairing and removes instructions that hazards force into a later slot from the fetch path.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_queue_if.sv | 47 ++++
 rtl/fq_mem.sv | 42 ++++
 rtl/fetch_queue.sv | 155 +++++++++++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the NOP encoding and the fetch-queue entry layout.
package cpu_pkg;

  localparam int          CPU_XLEN   = 32;
  localparam logic [31:0] NOP_INSTR  = 32'b0;
  localparam int          FQ_ENTRY_W = CPU_XLEN + CPU_XLEN + 1;

  typedef struct packed {
    logic [CPU_XLEN-1:0] instr;
    logic [CPU_XLEN-1:0] pc;
    logic                bp;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/issue-side signal bundle of the fetch queue; master = fetch+issue, slave = queue.
interface fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            fq_in_valid1;
  logic            fq_in_valid2;
  logic [XLEN-1:0] fq_in_instr1;
  logic [XLEN-1:0] fq_in_instr2;
  logic [XLEN-1:0] fq_in_pc1;
  logic [XLEN-1:0] fq_in_pc2;
  logic            fq_in_bp1;
  logic            fq_in_bp2;
  logic            fq_in_ready;
  logic            fq_out_valid1;
  logic            fq_out_valid2;
  logic [XLEN-1:0] fq_out_instr1;
  logic [XLEN-1:0] fq_out_instr2;
  logic [XLEN-1:0] fq_out_pc1;
  logic [XLEN-1:0] fq_out_pc2;
  logic            fq_out_bp1;
  logic            fq_out_bp2;
  logic [1:0]      fq_pop;
  logic            stall;
  logic            flush_signal1;
  logic            flush_signal2;
  logic [CW-1:0]   fq_count;

  modport master (
    output fq_in_valid1, fq_in_valid2, fq_in_instr1, fq_in_instr2,
           fq_in_pc1, fq_in_pc2, fq_in_bp1, fq_in_bp2,
           fq_pop, stall, flush_signal1, flush_signal2,
    input  fq_in_ready, fq_out_valid1, fq_out_valid2, fq_out_instr1, fq_out_instr2,
           fq_out_pc1, fq_out_pc2, fq_out_bp1, fq_out_bp2, fq_count
  );

  modport slave (
    input  fq_in_valid1, fq_in_valid2, fq_in_instr1, fq_in_instr2,
           fq_in_pc1, fq_in_pc2, fq_in_bp1, fq_in_bp2,
           fq_pop, stall, flush_signal1, flush_signal2,
    output fq_in_ready, fq_out_valid1, fq_out_valid2, fq_out_instr1, fq_out_instr2,
           fq_out_pc1, fq_out_pc2, fq_out_bp1, fq_out_bp2, fq_count
  );

endinterface

// File: rtl/fq_mem.sv
// Fetch-queue storage: DEPTH entries, two write ports (tail, tail+1), two read ports (head, head+1).
module fq_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 65
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  logic [W-1:0]  wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  logic [W-1:0]  wdata1_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output logic [W-1:0]  rdata0_o,
  output logic [W-1:0]  rdata1_o
);

  logic [W-1:0] mem_q [DEPTH];

  // The two write addresses are always distinct (tail and tail+1).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we0_i) begin
        mem_q[waddr0_i] <= wdata0_i;
      end
      if (we1_i) begin
        mem_q[waddr1_i] <= wdata1_i;
      end
    end
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: 2-wide compacted push, 0..2 pop, flush, occupancy count.
// Optional same-cycle bypass of an empty queue under `FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic         clk,
  input logic         rstn,
  fetch_queue_if.slave fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = XLEN + XLEN + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          flush_s, byp_s, we0_s, we1_s;
  logic [1:0]    push_num_s, pop_req_s, pop_num_s, byp_pop_s, wr_num_s;
  logic [W-1:0]  slot1_s, slot2_s, first_s, wdata0_s;
  logic [W-1:0]  rdata0_s, rdata1_s, out1_s, out2_s;
  logic          out_v1_s, out_v2_s;

  assign flush_s        = fq.flush_signal1 | fq.flush_signal2;
  assign fq.fq_in_ready = (count_q <= CW'(DEPTH - 2));
  assign fq.fq_count    = count_q;
  assign slot1_s        = {fq.fq_in_instr1, fq.fq_in_pc1, fq.fq_in_bp1};
  assign slot2_s        = {fq.fq_in_instr2, fq.fq_in_pc2, fq.fq_in_bp2};
  assign first_s        = fq.fq_in_valid1 ? slot1_s : slot2_s;

  // Push/pop amounts; in bypass, pops are satisfied from the incoming slots first.
  always_comb begin
    byp_s = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_s = (count_q == '0) && !flush_s;
`endif
    if (fq.fq_in_ready) begin
      push_num_s = {1'b0, fq.fq_in_valid1} + {1'b0, fq.fq_in_valid2};
    end else begin
      push_num_s = 2'd0;
    end
    if (fq.stall) begin
      pop_req_s = 2'd0;
    end else if (fq.fq_pop > 2'd2) begin
      pop_req_s = 2'd2;
    end else begin
      pop_req_s = fq.fq_pop;
    end
    if (CW'(pop_req_s) > count_q) begin
      pop_num_s = count_q[1:0];
    end else begin
      pop_num_s = pop_req_s;
    end
    if (!byp_s) begin
      byp_pop_s = 2'd0;
    end else if (pop_req_s > push_num_s) begin
      byp_pop_s = push_num_s;
    end else begin
      byp_pop_s = pop_req_s;
    end
    wr_num_s = push_num_s - byp_pop_s;
    if (byp_pop_s == 2'd1) begin
      wdata0_s = slot2_s;
    end else begin
      wdata0_s = first_s;
    end
  end

  assign we0_s = !flush_s && (wr_num_s != 2'd0);
  assign we1_s = !flush_s && (wr_num_s == 2'd2);

  // Pointer and count next state; flush wins over everything else.
  always_comb begin
    if (flush_s) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_num_s);
      tail_d  = tail_q + AW'(wr_num_s);
      count_d = count_q + CW'(wr_num_s) - CW'(pop_num_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (W)
  ) u_mem (
    .clk      (clk),
    .rstn     (rstn),
    .we0_i    (we0_s),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0_s),
    .we1_i    (we1_s),
    .waddr1_i (tail_q + AW'(1)),
    .wdata1_i (slot2_s),
    .raddr0_i (head_q),
    .raddr1_i (head_q + AW'(1)),
    .rdata0_o (rdata0_s),
    .rdata1_o (rdata1_s)
  );

  // Output slot selection; invalid slots present the all-zero NOP.
  always_comb begin
    if (byp_s) begin
      out_v1_s = (push_num_s != 2'd0);
      out_v2_s = (push_num_s == 2'd2);
      out1_s   = first_s;
      out2_s   = slot2_s;
    end else begin
      out_v1_s = (count_q != '0);
      out_v2_s = (count_q >= CW'(2));
      out1_s   = rdata0_s;
      out2_s   = rdata1_s;
    end
    fq.fq_out_valid1 = out_v1_s;
    fq.fq_out_valid2 = out_v2_s;
    if (out_v1_s) begin
      fq.fq_out_instr1 = out1_s[W-1 -: XLEN];
      fq.fq_out_pc1    = out1_s[XLEN -: XLEN];
      fq.fq_out_bp1    = out1_s[0];
    end else begin
      fq.fq_out_instr1 = XLEN'(NOP_INSTR);
      fq.fq_out_pc1    = '0;
      fq.fq_out_bp1    = 1'b0;
    end
    if (out_v2_s) begin
      fq.fq_out_instr2 = out2_s[W-1 -: XLEN];
      fq.fq_out_pc2    = out2_s[XLEN -: XLEN];
      fq.fq_out_bp2    = out2_s[0];
    end else begin
      fq.fq_out_instr2 = XLEN'(NOP_INSTR);
      fq.fq_out_pc2    = '0;
      fq.fq_out_bp2    = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: driver computes expectations from a queue model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] count;
    logic          ready;
    logic          v1;
    logic          v2;
    fq_entry_t     e1;
    fq_entry_t     e2;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fq   (fq)
  );

  always #5 clk = ~clk;

  exp_t            exp_q[$];
  fq_entry_t       model_q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [XLEN-1:0] pc_ctr = 32'h100;
  exp_t            mon_e;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("count",  96'(fq.fq_count),      96'(mon_e.count));
      chk("ready",  96'(fq.fq_in_ready),   96'(mon_e.ready));
      chk("valid1", 96'(fq.fq_out_valid1), 96'(mon_e.v1));
      chk("valid2", 96'(fq.fq_out_valid2), 96'(mon_e.v2));
      chk("slot1",  96'({fq.fq_out_instr1, fq.fq_out_pc1, fq.fq_out_bp1}), 96'(mon_e.e1));
      chk("slot2",  96'({fq.fq_out_instr2, fq.fq_out_pc2, fq.fq_out_bp2}), 96'(mon_e.e2));
    end
  end

  task automatic idle_inputs();
    fq.fq_in_valid1 = 1'b0; fq.fq_in_valid2 = 1'b0;
    fq.fq_in_instr1 = '0;   fq.fq_in_instr2 = '0;
    fq.fq_in_pc1    = '0;   fq.fq_in_pc2    = '0;
    fq.fq_in_bp1    = 1'b0; fq.fq_in_bp2    = 1'b0;
    fq.fq_pop       = 2'd0; fq.stall        = 1'b0;
    fq.flush_signal1 = 1'b0; fq.flush_signal2 = 1'b0;
  endtask

  // One cycle: drive inputs, queue the expected outputs for this cycle, advance the model.
  task automatic drive(input bit v1, input bit v2, input int pop, input bit st,
                       input bit f1, input bit f2);
    fq_entry_t s1, s2;
    fq_entry_t ins[$];
    exp_t      e;
    bit        rdy, byp;
    int        p;
    s1.instr = $urandom; s1.bp = 1'($urandom_range(0, 1));
    s2.instr = $urandom; s2.bp = 1'($urandom_range(0, 1));
    s1.pc = v1 ? pc_ctr : $urandom; if (v1) pc_ctr += 32'd4;
    s2.pc = v2 ? pc_ctr : $urandom; if (v2) pc_ctr += 32'd4;
    fq.fq_in_valid1 = v1; fq.fq_in_instr1 = s1.instr; fq.fq_in_pc1 = s1.pc; fq.fq_in_bp1 = s1.bp;
    fq.fq_in_valid2 = v2; fq.fq_in_instr2 = s2.instr; fq.fq_in_pc2 = s2.pc; fq.fq_in_bp2 = s2.bp;
    fq.fq_pop = 2'(pop); fq.stall = st; fq.flush_signal1 = f1; fq.flush_signal2 = f2;
    if (v1) ins.push_back(s1);
    if (v2) ins.push_back(s2);
    rdy = (model_q.size() <= DEPTH - 2);
    byp = BYP && (model_q.size() == 0) && !(f1 || f2);
    e.count = CW'(model_q.size());
    e.ready = rdy;
    if (byp) begin
      e.v1 = (ins.size() >= 1); e.e1 = e.v1 ? ins[0] : '0;
      e.v2 = (ins.size() == 2); e.e2 = e.v2 ? ins[1] : '0;
    end else begin
      e.v1 = (model_q.size() >= 1); e.e1 = e.v1 ? model_q[0] : '0;
      e.v2 = (model_q.size() >= 2); e.e2 = e.v2 ? model_q[1] : '0;
    end
    exp_q.push_back(e);
    if (f1 || f2) begin
      model_q.delete();
    end else begin
      if (!rdy) ins.delete();
      p = st ? 0 : pop;
      while (byp && p > 0 && ins.size() > 0) begin void'(ins.pop_front()); p--; end
      while (p > 0 && model_q.size() > 0) begin void'(model_q.pop_front()); p--; end
      foreach (ins[i]) model_q.push_back(ins[i]);
    end
    @(posedge clk); #1;
  endtask

  // Asynchronous reset asserted mid-cycle with the queue in an arbitrary state.
  task automatic async_reset();
    exp_t e;
    idle_inputs();
    #2 rstn = 1'b0;
    model_q.delete();
    e = '0;
    e.ready = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    drive(0, 0, 0, 0, 0, 0);                     // reset state
    drive(1, 1, 0, 0, 0, 0);                     // A 0x100, B 0x104
    drive(1, 0, 0, 0, 0, 0);                     // C
    drive(0, 0, 1, 0, 0, 0);                     // single pop
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 2, 0, 0, 0);                     // over-pop clamps
    drive(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0);  // fill to 8, then dropped
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(0, 0, 2, 0, 0, 0);
      else            drive(1, 1, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 2, 0, 0, 0);

    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 2, 1, 0, 0);                     // stall blocks pop, not push
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 1);                     // flush beats push/pop
    drive(0, 0, 0, 0, 0, 0);

    pc_ctr = 32'h200;
    drive(1, 1, 1, 0, 0, 0);                     // bypass candidate
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);                     // slot 2 alone
    drive(1, 1, 0, 0, 1, 0);                     // flush from pipe 1
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    async_reset();
    drive(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 31) == 0));
    end
    idle_inputs();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
